// File: rtl/dice_turn_if.sv
// Player/dice-side signal bundle for the dice turn controller.
interface dice_turn_if #(
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned SCORE_W   = 6
);
  logic [N_PLAYERS-1:0]         btn;
  logic                         new_game;
  logic [2:0]                   throw;
  logic                         dice_button;
  logic [1:0]                   turn;
  logic                         result_valid;
  logic [1:0]                   result_player;
  logic [2:0]                   result_value;
  logic [N_PLAYERS*SCORE_W-1:0] scores;
  logic                         game_over;
  logic [1:0]                   winner;

  // Environment side: drives buttons, clear and the dice value.
  modport master (
    output btn, new_game, throw,
    input  dice_button, turn, result_valid, result_player, result_value,
           scores, game_over, winner
  );

  // Controller side.
  modport slave (
    input  btn, new_game, throw,
    output dice_button, turn, result_valid, result_player, result_value,
           scores, game_over, winner
  );
endinterface

// File: rtl/dice_turn_ctrl.sv
// Round-robin turn scheduler and score keeper for a shared electronic dice.
module dice_turn_ctrl #(
  parameter int unsigned N_PLAYERS  = 2,
  parameter int unsigned MIN_ROLL   = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned TARGET     = 20,
  parameter int unsigned SCORE_W    = 6
) (
  input logic        clk,
  input logic        rst,
  dice_turn_if.slave bus
);

  localparam int unsigned ROLL_W   = (MIN_ROLL < 1) ? 1 : $clog2(MIN_ROLL + 1);
  localparam int unsigned SETTLE_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int unsigned SUM_W    = SCORE_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ROLL   = 3'd1,
    SETTLE = 3'd2,
    REPORT = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                dice_q, dice_d;
  logic [ROLL_W-1:0]   roll_q, roll_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [1:0]          turn_q, turn_d;
  logic                valid_q, valid_d;
  logic [1:0]          rplayer_q, rplayer_d;
  logic [2:0]          rvalue_q, rvalue_d;
  logic                over_q, over_d;
  logic [1:0]          winner_q, winner_d;
  logic [SCORE_W-1:0]  score_q [N_PLAYERS];
  logic [SCORE_W-1:0]  score_d [N_PLAYERS];

  logic                btn_turn;
  logic [SCORE_W-1:0]  score_turn;
  logic [SUM_W-1:0]    score_sum;
  logic [SCORE_W-1:0]  score_sat;
  logic                throw_ok;
  logic [1:0]          turn_next;

  // Select the current player's button and score.
  always_comb begin
    btn_turn   = 1'b0;
    score_turn = '0;
    for (int i = 0; i < int'(N_PLAYERS); i++) begin
      if (turn_q == 2'(i)) begin
        btn_turn   = bus.btn[i];
        score_turn = score_q[i];
      end
    end
  end

  assign score_sum = {1'b0, score_turn} + SUM_W'(bus.throw);
  assign score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  assign throw_ok  = (bus.throw != 3'd0) && (bus.throw != 3'd7);
  assign turn_next = (turn_q == 2'(N_PLAYERS - 1)) ? 2'd0 : turn_q + 2'd1;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    dice_d    = dice_q;
    roll_d    = roll_q;
    settle_d  = settle_q;
    turn_d    = turn_q;
    valid_d   = 1'b0;
    rplayer_d = rplayer_q;
    rvalue_d  = rvalue_q;
    over_d    = over_q;
    winner_d  = winner_q;
    score_d   = score_q;

    unique case (state_q)
      IDLE: begin
        dice_d = 1'b0;
        if (btn_turn) begin
          state_d = ROLL;
          dice_d  = 1'b1;
          roll_d  = ROLL_W'(1);
        end
      end
      ROLL: begin
        dice_d = 1'b1;
        if (roll_q < ROLL_W'(MIN_ROLL)) roll_d = roll_q + ROLL_W'(1);
        // An early release keeps rolling until the minimum length is met.
        if (!btn_turn && (roll_q >= ROLL_W'(MIN_ROLL))) begin
          state_d  = SETTLE;
          dice_d   = 1'b0;
          settle_d = '0;
        end
      end
      SETTLE: begin
        dice_d = 1'b0;
        if (settle_q < SETTLE_W'(SETTLE_CYC)) begin
          settle_d = settle_q + SETTLE_W'(1);
        end else if (throw_ok) begin
          state_d   = REPORT;
          valid_d   = 1'b1;
          rvalue_d  = bus.throw;
          rplayer_d = turn_q;
          for (int i = 0; i < int'(N_PLAYERS); i++) begin
            if (turn_q == 2'(i)) score_d[i] = score_sat;
          end
        end
      end
      REPORT: begin
        if (32'(score_turn) >= TARGET) begin
          state_d  = DONE;
          over_d   = 1'b1;
          winner_d = turn_q;
        end else begin
          // A six earns the same player another roll.
          if (rvalue_q != 3'd6) turn_d = turn_next;
          state_d = IDLE;
        end
      end
      DONE: begin
        dice_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        dice_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; new_game clears exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || bus.new_game) begin
      state_q   <= IDLE;
      dice_q    <= 1'b0;
      roll_q    <= '0;
      settle_q  <= '0;
      turn_q    <= '0;
      valid_q   <= 1'b0;
      rplayer_q <= '0;
      rvalue_q  <= '0;
      over_q    <= 1'b0;
      winner_q  <= '0;
      for (int i = 0; i < int'(N_PLAYERS); i++) score_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      dice_q    <= dice_d;
      roll_q    <= roll_d;
      settle_q  <= settle_d;
      turn_q    <= turn_d;
      valid_q   <= valid_d;
      rplayer_q <= rplayer_d;
      rvalue_q  <= rvalue_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
      score_q   <= score_d;
    end
  end

  assign bus.dice_button   = dice_q;
  assign bus.turn          = turn_q;
  assign bus.result_valid  = valid_q;
  assign bus.result_player = rplayer_q;
  assign bus.result_value  = rvalue_q;
  assign bus.game_over     = over_q;
  assign bus.winner        = winner_q;

  for (genvar g = 0; g < int'(N_PLAYERS); g++) begin : g_scores
    assign bus.scores[g*SCORE_W +: SCORE_W] = score_q[g];
  end

endmodule
